// File: rtl/jtcps1_pack_pkg.sv
// rtl/jtcps1_pack_pkg.sv - shared types and constants for the ROM-download write packer
// Contents: active-low byte-mask constants, 42-bit FIFO entry struct,
// pack FSM state encoding and the half-word merge helper.
package jtcps1_pack_pkg;

    localparam logic [1:0] MASK_LO = 2'b10;   // low byte only
    localparam logic [1:0] MASK_HI = 2'b01;   // high byte only
    localparam logic [1:0] MASK_W  = 2'b00;   // full word

    typedef struct packed {
        logic [1:0]  ba;
        logic [1:0]  mask;
        logic [15:0] data;
        logic [21:0] addr;
    } pack_entry_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HALF  = 1'b1
    } pack_state_t;

    // Combine two complementary halves of the same word. The low lane comes
    // from whichever half carried MASK_LO, the high lane from the other one.
    function automatic pack_entry_t merge_halves(input pack_entry_t a, input pack_entry_t b);
        pack_entry_t lo;
        pack_entry_t hi;
        pack_entry_t m;
        lo     = (a.mask == MASK_LO) ? a : b;
        hi     = (a.mask == MASK_LO) ? b : a;
        m      = a;
        m.mask = MASK_W;
        m.data = {hi.data[15:8], lo.data[7:0]};
        return m;
    endfunction

endpackage

// File: rtl/jtcps1_pack_fifo.sv
// rtl/jtcps1_pack_fifo.sv - small synchronous FIFO of packed SDRAM write entries
// Ports: clk, rst (sync, active high); push_a/din_a first entry, push_b/din_b
// second entry in the same cycle (only honoured together with push_a);
// pop; head (registered entry at the read pointer); full, empty, count.
// The caller guarantees there is room for every pushed entry.
import jtcps1_pack_pkg::*;

module jtcps1_pack_fifo #(
    parameter int AW = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_a,
    input  pack_entry_t din_a,
    input  logic        push_b,
    input  pack_entry_t din_b,
    input  logic        pop,
    output pack_entry_t head,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);

    localparam int DEPTH = 1 << AW;

    pack_entry_t   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_pop;
    logic          do_push_b;
    logic [1:0]    npush;

    assign do_pop    = pop && !empty;
    assign do_push_b = push_a && push_b;
    assign npush     = {1'b0, push_a} + {1'b0, do_push_b};

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_a)    mem[wr_ptr]           <= din_a;
        if (do_push_b) mem[wr_ptr + AW'(1)]  <= din_b;
    end

    // Pointers wrap naturally at DEPTH; a push and a pop on a full FIFO
    // leave the occupancy unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(npush);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + (AW+1)'(npush) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/jtcps1_prog_pack.sv
// rtl/jtcps1_prog_pack.sv - merges byte-lane ROM-download writes into 16-bit SDRAM writes
// Upstream: prog_addr/prog_data/prog_mask/prog_ba/prog_we in, prog_rdy accept pulse out.
// SDRAM: sdram_addr/din/mask/ba and sdram_wr out (FIFO head), sdram_ack in (pop).
// Control: clk, rst (sync, active high), downloading (falling edge flushes),
// pack_busy out. Optional macro JTCPS1_PACK_CHK_EN adds pack_chk[15:0],
// a running sum of the enabled byte lanes of every word sent to SDRAM.
import jtcps1_pack_pkg::*;

module jtcps1_prog_pack #(
    parameter int         FIFO_AW = 2,
    parameter logic [5:0] TOUT    = 6'd32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        downloading,
    input  logic [21:0] prog_addr,
    input  logic [15:0] prog_data,
    input  logic [1:0]  prog_mask,
    input  logic [1:0]  prog_ba,
    input  logic        prog_we,
    output logic        prog_rdy,
    output logic [21:0] sdram_addr,
    output logic [15:0] sdram_din,
    output logic [1:0]  sdram_mask,
    output logic [1:0]  sdram_ba,
    output logic        sdram_wr,
    input  logic        sdram_ack,
    output logic        pack_busy
`ifdef JTCPS1_PACK_CHK_EN
    ,output logic [15:0] pack_chk
`endif
);

    localparam int DEPTH = 1 << FIFO_AW;

    pack_state_t      state;
    pack_entry_t      pend;
    logic [5:0]       cnt;
    logic             flush_req;
    logic             dl_q;

    pack_entry_t      new_e;
    pack_entry_t      head;
    pack_entry_t      din_a;
    pack_entry_t      din_b;
    logic             push_a;
    logic             push_b;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FIFO_AW:0] fifo_count;

    logic             do_pop;
    logic [FIFO_AW:0] free;
    logic [1:0]       need;
    logic             dl_fall;
    logic             flush;
    logic             flush_go;
    logic             can_merge;
    logic             capture;

    assign new_e = '{ba: prog_ba, mask: prog_mask, data: prog_data, addr: prog_addr};

    assign do_pop  = sdram_ack && !fifo_empty;
    // A slot freed by this cycle's pop is usable by this cycle's push.
    assign free    = (FIFO_AW+1)'(DEPTH) - fifo_count + (FIFO_AW+1)'(do_pop);
    assign dl_fall = dl_q && !downloading;

    // A pending half leaves on timeout or on the end of the download; a
    // falling edge that arrives while the FIFO is full is remembered.
    assign flush    = (state == ST_HALF) && ((cnt == TOUT) || flush_req || dl_fall);
    assign flush_go = flush && (!fifo_full || do_pop);

    assign can_merge = (state == ST_HALF) && (pend.addr == prog_addr) && (pend.ba == prog_ba) &&
                       (((prog_mask == MASK_LO) && (pend.mask == MASK_HI)) ||
                        ((prog_mask == MASK_HI) && (pend.mask == MASK_LO)));

    // Slots the capture would consume: a lone half in EMPTY costs nothing,
    // a non-matching write in HALF also evicts the pending half.
    always_comb begin
        need = 2'd0;
        if (state == ST_EMPTY)
            need = (prog_mask == MASK_W) ? 2'd1 : 2'd0;
        else if (can_merge)
            need = 2'd1;
        else
            need = (prog_mask == MASK_W) ? 2'd2 : 2'd1;
    end

    assign capture = prog_we && !prog_rdy && !flush && (free >= (FIFO_AW+1)'(need));

    always_comb begin
        push_a = 1'b0;
        push_b = 1'b0;
        din_a  = new_e;
        din_b  = new_e;
        if (flush_go) begin
            push_a = 1'b1;
            din_a  = pend;
        end else if (capture) begin
            if (state == ST_EMPTY) begin
                push_a = (prog_mask == MASK_W);
            end else if (can_merge) begin
                push_a = 1'b1;
                din_a  = merge_halves(pend, new_e);
            end else begin
                push_a = 1'b1;
                din_a  = pend;
                push_b = (prog_mask == MASK_W);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            pend      <= '0;
            cnt       <= '0;
            flush_req <= 1'b0;
            dl_q      <= 1'b0;
            prog_rdy  <= 1'b0;
        end else begin
            dl_q     <= downloading;
            prog_rdy <= capture;
            if (flush_go) begin
                state     <= ST_EMPTY;
                cnt       <= '0;
                flush_req <= 1'b0;
            end else if (capture) begin
                cnt <= '0;
                if (state == ST_HALF && can_merge) begin
                    state <= ST_EMPTY;
                end else if (prog_mask == MASK_W) begin
                    state <= ST_EMPTY;
                end else begin
                    pend  <= new_e;
                    state <= ST_HALF;
                end
            end else if (state == ST_HALF) begin
                if (cnt != TOUT) cnt <= cnt + 6'd1;
                if (dl_fall) flush_req <= 1'b1;
            end else begin
                cnt       <= '0;
                flush_req <= 1'b0;
            end
        end
    end

    jtcps1_pack_fifo #(.AW(FIFO_AW)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_a (push_a),
        .din_a  (din_a),
        .push_b (push_b),
        .din_b  (din_b),
        .pop    (sdram_ack),
        .head   (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // Outputs read zero while the FIFO is empty so stale memory never shows.
    assign sdram_wr   = !fifo_empty;
    assign sdram_addr = fifo_empty ? '0 : head.addr;
    assign sdram_din  = fifo_empty ? '0 : head.data;
    assign sdram_mask = fifo_empty ? '0 : head.mask;
    assign sdram_ba   = fifo_empty ? '0 : head.ba;
    assign pack_busy  = (state == ST_HALF) || !fifo_empty;

`ifdef JTCPS1_PACK_CHK_EN
    logic [15:0] chk;

    always_ff @(posedge clk) begin
        if (rst || (!dl_q && downloading))
            chk <= '0;
        else if (do_pop)
            chk <= chk + {head.mask[1] ? 8'h00 : head.data[15:8],
                          head.mask[0] ? 8'h00 : head.data[7:0]};
    end

    assign pack_chk = chk;
`endif

endmodule
